alu_resp_checker: RTL and testbench

ALU_RESP_CHECKER -- requirements
Module: alu_resp_checker

---
 rtl/alu_resp_checker.sv | 138 +++++++++++++
 tb/tb_alu_resp_checker.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_checker.sv
// Scoreboard-style checker for an 8-bit ADD/SUB/AND/OR ALU: captures one observed
// transaction, recomputes Y/OVF, reports a verdict and keeps pass/fail statistics.
module alu_resp_checker #(
    parameter int CNT_W      = 16,
    parameter int FAIL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic [1:0]       OP_SEL,
    input  logic [7:0]       dut_y,
    input  logic             dut_ovf,
    input  logic             stat_clr,
    output logic             chk_done,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic             halted,
    output logic [26:0]      ff_rec,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       a_r, b_r, y_r, exp_y, calc_y, sum, diff;
    logic [1:0]       op_r;
    logic             ovf_r, exp_ovf, calc_ovf;
    logic             handshake, verdict_fail, limit_hit, upd_q;
    logic [CNT_W-1:0] fail_next, pass_next;

    // A transfer happens on a rising edge where in_valid && in_ready; in_ready
    // depends only on state, and operands are sampled only on that edge.
    assign in_ready  = (state == IDLE);
    assign halted    = (state == HALT);
    assign dbg_state = state;
    assign handshake = in_valid && in_ready;

    always_comb begin
        sum      = a_r + b_r;
        diff     = a_r - b_r;
        calc_y   = sum;
        calc_ovf = 1'b0;
        case (op_r)
            2'b00: begin
                calc_y   = sum;
                calc_ovf = (a_r[7] == b_r[7]) && (sum[7] != a_r[7]);
            end
            2'b01: begin
                calc_y   = diff;
                calc_ovf = (a_r[7] != b_r[7]) && (diff[7] != a_r[7]);
            end
            2'b10:   calc_y = a_r & b_r;
            default: calc_y = a_r | b_r;
        endcase
    end

    assign verdict_fail = (y_r != exp_y) || (ovf_r != exp_ovf);
    assign fail_next    = (&fail_cnt) ? fail_cnt : fail_cnt + CNT_W'(1);
    assign pass_next    = (&pass_cnt) ? pass_cnt : pass_cnt + CNT_W'(1);
    // Halt is decided on the count this failure will produce, one edge before it lands.
    assign limit_hit    = (FAIL_LIMIT != 0) && (32'(fail_next) >= 32'(FAIL_LIMIT));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EVAL;
            EVAL:    state_nxt = REPORT;
            REPORT:  state_nxt = (!stat_clr && verdict_fail && limit_hit) ? HALT : IDLE;
            HALT:    if (stat_clr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            y_r        <= '0;
            ovf_r      <= 1'b0;
            exp_y      <= '0;
            exp_ovf    <= 1'b0;
            chk_done   <= 1'b0;
            mismatch   <= 1'b0;
            upd_q      <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
            ff_rec     <= '0;
        end else begin
            if (handshake) begin
                a_r   <= A;
                b_r   <= B;
                op_r  <= OP_SEL;
                y_r   <= dut_y;
                ovf_r <= dut_ovf;
            end
            if (state == EVAL) begin
                exp_y   <= calc_y;
                exp_ovf <= calc_ovf;
            end
            chk_done <= (state == REPORT);
            mismatch <= (state == REPORT) && verdict_fail;
            // A clear on the verdict edge cancels that transaction's statistics update.
            upd_q    <= (state == REPORT) && !stat_clr;
            if (stat_clr) begin
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                err_sticky <= 1'b0;
                ff_rec     <= '0;
            end else if (upd_q) begin
                if (mismatch) begin
                    fail_cnt   <= fail_next;
                    err_sticky <= 1'b1;
                    if (!err_sticky) ff_rec <= {op_r, a_r, b_r, y_r, ovf_r};
                end else begin
                    pass_cnt <= pass_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench for alu_resp_checker: a default instance and a CNT_W=2/FAIL_LIMIT=2 instance
// share one stimulus stream and are compared each cycle against a timeline model.
module tb_alu_resp_checker;

    logic        clk, reset, in_valid, stat_clr, dut_ovf;
    logic [7:0]  A, B, dut_y;
    logic [1:0]  OP_SEL;

    logic        rdy0, done0, mis0, stk0, hlt0;
    logic [15:0] pass0, fail0;
    logic [26:0] rec0;
    logic [1:0]  dbg0;
    logic        rdy1, done1, mis1, stk1, hlt1;
    logic [1:0]  pass1, fail1;
    logic [26:0] rec1;
    logic [1:0]  dbg1;

    int n_checks = 0;
    int n_pass   = 0;

    alu_resp_checker u_main (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .A(A), .B(B), .OP_SEL(OP_SEL), .dut_y(dut_y), .dut_ovf(dut_ovf),
        .stat_clr(stat_clr), .chk_done(done0), .mismatch(mis0),
        .pass_cnt(pass0), .fail_cnt(fail0), .err_sticky(stk0), .halted(hlt0),
        .ff_rec(rec0), .dbg_state(dbg0)
    );

    alu_resp_checker #(.CNT_W(2), .FAIL_LIMIT(2)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .A(A), .B(B), .OP_SEL(OP_SEL), .dut_y(dut_y), .dut_ovf(dut_ovf),
        .stat_clr(stat_clr), .chk_done(done1), .mismatch(mis1),
        .pass_cnt(pass1), .fail_cnt(fail1), .err_sticky(stk1), .halted(hlt1),
        .ff_rec(rec1), .dbg_state(dbg1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference arithmetic ----------------
    function automatic void ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] y, output logic ovf);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        y   = r[7:0];
        ovf = (op < 2'd2) && (r > 127 || r < -128);
    endfunction

    // ---------------- timeline model ----------------
    int          lim[2]  = '{8, 2};
    int          maxv[2] = '{65535, 3};
    int          cyc     = 0;
    bit          m_busy[2], m_halt[2], m_done[2], m_mis[2], m_upd[2], m_fail[2], m_sticky[2];
    int          hs_e[2], m_pass[2], m_failc[2];
    logic [26:0] m_trec[2], m_rec[2];

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_reset(input int k);
        m_busy[k]   = 0;
        m_halt[k]   = 0;
        m_done[k]   = 0;
        m_mis[k]    = 0;
        m_upd[k]    = 0;
        m_fail[k]   = 0;
        m_sticky[k] = 0;
        m_pass[k]   = 0;
        m_failc[k]  = 0;
        m_rec[k]    = '0;
        m_trec[k]   = '0;
        hs_e[k]     = 0;
    endtask

    task automatic model_step(input int k);
        bit         rdy;
        logic [7:0] ey;
        logic       eo;
        rdy = !m_busy[k] && !m_halt[k];
        m_done[k] = 0;
        m_mis[k]  = 0;
        if (m_upd[k]) begin
            m_upd[k] = 0;
            if (!stat_clr) begin
                if (m_fail[k]) begin
                    m_failc[k] = sat_inc(m_failc[k], maxv[k]);
                    if (!m_sticky[k]) m_rec[k] = m_trec[k];
                    m_sticky[k] = 1;
                end else begin
                    m_pass[k] = sat_inc(m_pass[k], maxv[k]);
                end
            end
        end
        if (m_busy[k] && cyc == hs_e[k] + 2) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_mis[k]  = m_fail[k];
            if (!stat_clr) begin
                m_upd[k] = 1;
                if (m_fail[k] && lim[k] != 0 && sat_inc(m_failc[k], maxv[k]) >= lim[k]) m_halt[k] = 1;
            end
        end
        if (stat_clr) begin
            m_pass[k]   = 0;
            m_failc[k]  = 0;
            m_sticky[k] = 0;
            m_rec[k]    = '0;
            m_halt[k]   = 0;
        end
        if (rdy && in_valid) begin
            ref_alu(OP_SEL, A, B, ey, eo);
            m_busy[k] = 1;
            hs_e[k]   = cyc;
            m_fail[k] = (dut_y !== ey) || (dut_ovf !== eo);
            m_trec[k] = {OP_SEL, A, B, dut_y, dut_ovf};
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) model_reset(k);
        end else begin
            model_step(0);
            model_step(1);
            cyc++;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    endtask

    task automatic cmp_inst(input int k, input logic r, input logic d, input logic m,
                            input logic [31:0] p, input logic [31:0] f, input logic s,
                            input logic h, input logic [26:0] rec);
        chk("in_ready", k, 32'(r), 32'(!m_busy[k] && !m_halt[k]));
        chk("chk_done", k, 32'(d), 32'(m_done[k]));
        chk("mismatch", k, 32'(m), 32'(m_mis[k]));
        chk("pass_cnt", k, p, 32'(m_pass[k]));
        chk("fail_cnt", k, f, 32'(m_failc[k]));
        chk("err_sticky", k, 32'(s), 32'(m_sticky[k]));
        chk("halted", k, 32'(h), 32'(m_halt[k]));
        chk("ff_rec", k, 32'(rec), 32'(m_rec[k]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, rdy0, done0, mis0, 32'(pass0), 32'(fail0), stk0, hlt0, rec0);
        cmp_inst(1, rdy1, done1, mis1, 32'(pass1), 32'(fail1), stk1, hlt1, rec1);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] y, input logic ovf);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        OP_SEL   = op;
        A        = a;
        B        = b;
        dut_y    = y;
        dut_ovf  = ovf;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 8'($urandom_range(0, 255));
        B        = 8'($urandom_range(0, 255));
    endtask

    task automatic to_verdict();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic to_counters();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [26:0] exp_rec;
    logic [7:0]  ry;
    logic        ro;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        stat_clr = 1'b0;
        A        = '0;
        B        = '0;
        OP_SEL   = '0;
        dut_y    = '0;
        dut_ovf  = 1'b0;
        exp_rec  = {2'b01, 8'h80, 8'h01, 8'h7F, 1'b0};
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 0, 32'(rdy0), 32'd1);
        chk("rst_pass_cnt", 0, 32'(pass0), 32'd0);
        chk("rst_ff_rec", 0, 32'(rec0), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ADD overflow reported correctly by the ALU
        send(2'd0, 8'h7F, 8'h01, 8'h80, 1'b1);
        to_verdict();
        chk("add_done", 0, 32'(done0), 32'd1);
        chk("add_mismatch", 0, 32'(mis0), 32'd0);
        to_counters();
        chk("add_pass_cnt", 0, 32'(pass0), 32'd1);
        chk("model_pass_cnt", 0, 32'(m_pass[0]), 32'd1);

        // SUB overflow missed by the ALU
        send(2'd1, 8'h80, 8'h01, 8'h7F, 1'b0);
        to_verdict();
        chk("sub_done", 0, 32'(done0), 32'd1);
        chk("sub_mismatch", 0, 32'(mis0), 32'd1);
        to_counters();
        chk("sub_fail_cnt", 0, 32'(fail0), 32'd1);
        chk("sub_sticky", 0, 32'(stk0), 32'd1);
        chk("sub_ff_rec", 0, 32'(rec0), 32'(exp_rec));
        chk("model_ff_rec", 0, 32'(m_rec[0]), 32'(exp_rec));

        // OR passes, AND with a wrong Y fails; first-fail record must not move
        send(2'd3, 8'hFF, 8'h01, 8'hFF, 1'b0);
        to_verdict();
        chk("or_mismatch", 0, 32'(mis0), 32'd0);
        to_counters();
        send(2'd2, 8'hFF, 8'h01, 8'h00, 1'b0);
        to_verdict();
        chk("and_mismatch", 0, 32'(mis0), 32'd1);
        chk("small_halted", 1, 32'(hlt1), 32'd1);
        to_counters();
        chk("and_fail_cnt", 0, 32'(fail0), 32'd2);
        chk("and_pass_cnt", 0, 32'(pass0), 32'd2);
        chk("and_ff_rec", 0, 32'(rec0), 32'(exp_rec));
        chk("small_fail_cnt", 1, 32'(fail1), 32'd2);

        // Halted instance refuses a held in_valid until stat_clr
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        OP_SEL   = 2'd0;
        A        = 8'd1;
        B        = 8'd1;
        dut_y    = 8'd2;
        dut_ovf  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("halt_in_ready", 1, 32'(rdy1), 32'd0);
            chk("halt_halted", 1, 32'(hlt1), 32'd1);
        end
        @(posedge clk);
        #1 stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_in_ready", 1, 32'(rdy1), 32'd1);
        chk("clr_halted", 1, 32'(hlt1), 32'd0);
        chk("clr_fail_cnt", 1, 32'(fail1), 32'd0);
        chk("clr_sticky", 1, 32'(stk1), 32'd0);
        repeat (6) @(posedge clk);

        // Reset while the transaction sits in EVAL: no verdict, then normal operation
        send(2'd0, 8'h10, 8'h20, 8'h30, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_eval_done", 0, 32'(done0), 32'd0);
            chk("rst_eval_done", 1, 32'(done1), 32'd0);
        end
        chk("rst_eval_pass", 0, 32'(pass0), 32'd0);
        send(2'd0, 8'h10, 8'h20, 8'h30, 1'b0);
        to_verdict();
        chk("post_rst_done", 0, 32'(done0), 32'd1);
        to_counters();
        chk("post_rst_pass", 0, 32'(pass0), 32'd1);

        // Saturation of the 2-bit counter
        repeat (5) begin
            send(2'd1, 8'h05, 8'h03, 8'h02, 1'b0);
            to_verdict();
            to_counters();
        end
        chk("sat_pass_cnt", 1, 32'(pass1), 32'd3);
        chk("wide_pass_cnt", 0, 32'(pass0), 32'd6);

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (reset) reset = 1'b0;
            else       reset = ($urandom_range(0, 499) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            OP_SEL   = 2'($urandom_range(0, 3));
            A        = 8'($urandom_range(0, 255));
            B        = 8'($urandom_range(0, 255));
            ref_alu(OP_SEL, A, B, ry, ro);
            dut_y    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : ry;
            dut_ovf  = ($urandom_range(0, 7) == 0) ? ~ro : ro;
            stat_clr = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        stat_clr = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
